// File: rtl/filter_output_packer_pkg.sv
// Shared tag constants, packer FSM states and the FIFO word layout for the filter stages.
package filter_output_packer_pkg;

    localparam int TAG_W = 2;

    localparam logic [TAG_W-1:0] TAG_INVALID  = 2'd0;
    localparam logic [TAG_W-1:0] TAG_DATA0    = 2'd1;
    localparam logic [TAG_W-1:0] TAG_DATA1    = 2'd2;
    localparam logic [TAG_W-1:0] TAG_DATA_END = 2'd3;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } pack_state_t;

    typedef struct packed {
        logic        last;
        logic [2:0]  bytes;
        logic [31:0] data;
    } packed_word_t;

endpackage

// File: rtl/word_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO only lands if a pop happens on the same edge.
module word_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/filter_output_packer.sv
// Packs the tagged pixel stream into 32-bit words (first pixel in the low byte) and queues them
// behind a valid/ready interface, with frame statistics and end-of-frame tracking.
//
// state      | meaning
// COLLECT    | accepting pixels, packing lanes, pushing words
// DRAIN      | end word queued; input ignored until it is popped
// DONE       | frame finished; held until rst/refresh
module filter_output_packer
    import filter_output_packer_pkg::*;
#(
    parameter int                   TAG_WIDTH    = 2,
    parameter logic [TAG_WIDTH-1:0] INVALID_TAG  = TAG_WIDTH'(TAG_INVALID),
    parameter logic [TAG_WIDTH-1:0] DATA_TAG0    = TAG_WIDTH'(TAG_DATA0),
    parameter logic [TAG_WIDTH-1:0] DATA_TAG1    = TAG_WIDTH'(TAG_DATA1),
    parameter logic [TAG_WIDTH-1:0] DATA_END_TAG = TAG_WIDTH'(TAG_DATA_END),
    parameter int                   DATA_WIDTH   = 8 + TAG_WIDTH,
    parameter int                   FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  refresh,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [31:0]           out_data,
    output logic [2:0]            out_bytes,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [19:0]           pixel_count,
    output logic [9:0]            line_count,
    output logic                  done,
    output logic                  overflow
);

    pack_state_t            state_q, state_d;
    logic [TAG_WIDTH-1:0]   tag;
    logic [7:0]             pix;
    logic                   clear;
    logic                   is_end;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic                   dropped;
    logic [1:0]             lane_cnt;
    logic [23:0]            pack_reg;
    logic [31:0]            word_data;
    logic [TAG_WIDTH-1:0]   line_tag;
    packed_word_t           push_word;
    packed_word_t           head;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign tag     = data_in[DATA_WIDTH-1:8];
    assign pix     = data_in[7:0];
    assign clear   = rst || refresh;
    assign is_end  = (tag == DATA_END_TAG);
    assign accept  = (state_q == ST_COLLECT) && (tag != INVALID_TAG) &&
                     ((tag == DATA_TAG0) || (tag == DATA_TAG1) || is_end);
    assign push    = accept && ((lane_cnt == 2'd3) || is_end);
    assign pop     = out_ready && !fifo_empty;
    assign dropped = push && fifo_full && !pop;

    // Unused upper lanes stay zero because pack_reg is cleared on every push.
    assign word_data = {8'h00, pack_reg} | ({24'h000000, pix} << {lane_cnt, 3'b000});

    assign push_word.last  = is_end;
    assign push_word.bytes = {1'b0, lane_cnt} + 3'd1;
    assign push_word.data  = word_data;

    word_fifo #(
        .WIDTH ($bits(packed_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk       (clk),
        .rst       (clear),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (clear) state_q <= ST_COLLECT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COLLECT: if (push && is_end) state_d = dropped ? ST_DONE : ST_DRAIN;
            ST_DRAIN:   if (pop && head.last) state_d = ST_DONE;
            ST_DONE:    state_d = ST_DONE;
            default:    state_d = ST_COLLECT;
        endcase
    end

    // The end tag closes the current line, so only DATA_TAG0/DATA_TAG1 changes open a new one.
    always_ff @(posedge clk) begin
        if (clear) begin
            lane_cnt    <= 2'd0;
            pack_reg    <= 24'h000000;
            pixel_count <= 20'd0;
            line_count  <= 10'd0;
            line_tag    <= INVALID_TAG;
            overflow    <= 1'b0;
        end else begin
            if (accept) begin
                if (push) begin
                    lane_cnt <= 2'd0;
                    pack_reg <= 24'h000000;
                end else begin
                    lane_cnt <= lane_cnt + 2'd1;
                    pack_reg <= word_data[23:0];
                end
                if (pixel_count != 20'hFFFFF) pixel_count <= pixel_count + 20'd1;
                if (line_count == 10'd0) begin
                    line_count <= 10'd1;
                end else if (!is_end && (tag != line_tag) && (line_count != 10'h3FF)) begin
                    line_count <= line_count + 10'd1;
                end
                if (!is_end) line_tag <= tag;
            end
            if (dropped) overflow <= 1'b1;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 32'h0 : head.data;
    assign out_bytes = fifo_empty ? 3'd0  : head.bytes;
    assign out_last  = fifo_empty ? 1'b0  : head.last;
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_filter_output_packer.sv
// Directed bench for filter_output_packer: packing, end-of-frame, line counting, overflow and refresh.
module tb_filter_output_packer;

    localparam logic [1:0] T_INV = 2'd0;
    localparam logic [1:0] T_D0  = 2'd1;
    localparam logic [1:0] T_D1  = 2'd2;
    localparam logic [1:0] T_END = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        refresh;
    logic [9:0]  data_in;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] pixel_count;
    logic [9:0]  line_count;
    logic        done;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    filter_output_packer dut (
        .clk         (clk),
        .rst         (rst),
        .refresh     (refresh),
        .data_in     (data_in),
        .out_data    (out_data),
        .out_bytes   (out_bytes),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pixel_count (pixel_count),
        .line_count  (line_count),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] t, input logic [7:0] p);
        data_in = {t, p};
        tick();
        data_in = {T_INV, 8'h00};
    endtask

    task automatic do_refresh();
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
    endtask

    // Word k of a ramp stream whose pixel n carries value n.
    function automatic logic [31:0] ramp_word(input int k);
        logic [7:0] b;
        b = 8'(4 * k);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        refresh   = 1'b0;
        out_ready = 1'b0;
        data_in   = {T_INV, 8'h00};
        tick();
        tick();
        rst = 1'b0;

        chk("reset_out_valid",   32'(out_valid),   32'h0);
        chk("reset_out_data",    out_data,         32'h0);
        chk("reset_pixel_count", 32'(pixel_count), 32'h0);
        chk("reset_line_count",  32'(line_count),  32'h0);
        chk("reset_done",        32'(done),        32'h0);
        chk("reset_overflow",    32'(overflow),    32'h0);

        // Full word, latency one clock after the 4th pixel.
        out_ready = 1'b1;
        send(T_D0, 8'h11);
        send(T_D0, 8'h22);
        send(T_D0, 8'h33);
        chk("full_word_not_early", 32'(out_valid), 32'h0);
        send(T_D0, 8'h44);
        chk("full_word_valid", 32'(out_valid), 32'h1);
        chk("full_word_data",  out_data,       32'h44332211);
        chk("full_word_bytes", 32'(out_bytes), 32'h4);
        chk("full_word_last",  32'(out_last),  32'h0);
        tick();
        chk("full_word_popped", 32'(out_valid),   32'h0);
        chk("full_word_pixels", 32'(pixel_count), 32'd4);
        chk("full_word_lines",  32'(line_count),  32'd1);

        // Partial end-of-frame word.
        do_refresh();
        send(T_D0, 8'hA0);
        send(T_D0, 8'hA1);
        send(T_END, 8'hA2);
        chk("end_word_valid", 32'(out_valid), 32'h1);
        chk("end_word_data",  out_data,       32'h00A2A1A0);
        chk("end_word_bytes", 32'(out_bytes), 32'h3);
        chk("end_word_last",  32'(out_last),  32'h1);
        chk("end_not_done_yet", 32'(done),    32'h0);
        tick();
        chk("end_done",       32'(done),        32'h1);
        chk("end_drained",    32'(out_valid),   32'h0);
        chk("end_pixels",     32'(pixel_count), 32'd3);
        send(T_D0, 8'h55);
        chk("done_ignores_pixels", 32'(pixel_count), 32'd3);
        chk("done_no_word",        32'(out_valid),   32'h0);
        chk("done_held",           32'(done),        32'h1);

        // Two lines with interleaved invalid slots.
        do_refresh();
        chk("refresh_leaves_done", 32'(done), 32'h0);
        send(T_D0,  8'h01);
        send(T_INV, 8'hFF);
        send(T_D0,  8'h02);
        send(T_D0,  8'h03);
        send(T_INV, 8'hEE);
        send(T_D0,  8'h04);
        chk("line0_word", out_data, 32'h04030201);
        send(T_D1,  8'h05);
        send(T_INV, 8'hDD);
        send(T_D1,  8'h06);
        send(T_D1,  8'h07);
        send(T_D1,  8'h08);
        chk("line1_word",   out_data,         32'h08070605);
        chk("line1_valid",  32'(out_valid),   32'h1);
        chk("lines_count",  32'(line_count),  32'd2);
        chk("lines_pixels", 32'(pixel_count), 32'd8);

        // Push and pop on the same edge while full: no drop.
        do_refresh();
        out_ready = 1'b0;
        for (int i = 0; i < 35; i++) send(T_D0, 8'(i));
        chk("full_no_overflow_yet", 32'(overflow), 32'h0);
        out_ready = 1'b1;
        send(T_D0, 8'd35);
        chk("full_pushpop_no_overflow", 32'(overflow), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("full_pushpop_word%0d", k), out_data, ramp_word(k));
            tick();
        end
        chk("full_pushpop_empty", 32'(out_valid), 32'h0);

        // Overflow: 10 words into a depth-8 FIFO with no reader.
        do_refresh();
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) send(T_D0, 8'(i));
        chk("ovf_flag",   32'(overflow),    32'h1);
        chk("ovf_valid",  32'(out_valid),   32'h1);
        chk("ovf_head",   out_data,         32'h03020100);
        chk("ovf_pixels", 32'(pixel_count), 32'd40);
        tick();
        chk("ovf_head_stable",  out_data,       32'h03020100);
        chk("ovf_bytes_stable", 32'(out_bytes), 32'h4);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ovf_word%0d_valid", k), 32'(out_valid), 32'h1);
            chk($sformatf("ovf_word%0d_data", k),  out_data,       ramp_word(k));
            tick();
        end
        chk("ovf_only_eight", 32'(out_valid), 32'h0);
        chk("ovf_sticky",     32'(overflow),  32'h1);

        // Refresh mid-word while a word is waiting.
        out_ready = 1'b0;
        send(T_D0, 8'hB0);
        send(T_D0, 8'hB1);
        send(T_D0, 8'hB2);
        send(T_D0, 8'hB3);
        send(T_D0, 8'hB4);
        send(T_D0, 8'hB5);
        chk("pre_refresh_valid", 32'(out_valid), 32'h1);
        do_refresh();
        chk("refresh_valid",    32'(out_valid),   32'h0);
        chk("refresh_data",     out_data,         32'h0);
        chk("refresh_bytes",    32'(out_bytes),   32'h0);
        chk("refresh_last",     32'(out_last),    32'h0);
        chk("refresh_pixels",   32'(pixel_count), 32'h0);
        chk("refresh_lines",    32'(line_count),  32'h0);
        chk("refresh_done",     32'(done),        32'h0);
        chk("refresh_overflow", 32'(overflow),    32'h0);
        out_ready = 1'b1;
        send(T_D0, 8'hC0);
        send(T_D0, 8'hC1);
        send(T_D0, 8'hC2);
        send(T_D0, 8'hC3);
        chk("after_refresh_word",   out_data,         32'hC3C2C1C0);
        chk("after_refresh_bytes",  32'(out_bytes),   32'h4);
        chk("after_refresh_pixels", 32'(pixel_count), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/filter_output_packer.md
FILTER_OUTPUT_PACKER -- requirements
Module: filter_output_packer

Interface
REQ-001 Parameter TAG_WIDTH, default 2, is the tag field width.
REQ-002 Parameter INVALID_TAG, default 2'd0, marks a non-pixel slot.
REQ-003 Parameter DATA_TAG0, default 2'd1, marks a valid pixel on even lines.
REQ-004 Parameter DATA_TAG1, default 2'd2, marks a valid pixel on odd lines.
REQ-005 Parameter DATA_END_TAG, default 2'd3, marks the last valid pixel of a frame.
REQ-006 Parameter DATA_WIDTH, default 8+TAG_WIDTH, is the tagged-pixel width; pixel is [7:0], tag is [DATA_WIDTH-1:8].
REQ-007 Parameter FIFO_DEPTH, default 8, is the output word FIFO depth (power of two, >=2).
REQ-008 Port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-009 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-010 Port refresh, input, 1 bit: synchronous frame restart, same effect as rst.
REQ-011 Port data_in, input, DATA_WIDTH bits: tagged pixel stream from the filter stage, one per clk, no stall.
REQ-012 Port out_data, output, 32 bits: packed word, first pixel in [7:0].
REQ-013 Port out_bytes, output, 3 bits: valid bytes in out_data (1-4).
REQ-014 Port out_last, output, 1 bit: word is the final word of the frame.
REQ-015 Port out_valid, output, 1 bit; out_ready, input, 1 bit: valid/ready handshake, transfer when both high.
REQ-016 Port pixel_count, output, 20 bits; line_count, output, 10 bits: frame statistics.
REQ-017 Port done, output, 1 bit; overflow, output, 1 bit: status flags.

Function
REQ-018 Slots tagged INVALID_TAG shall be discarded with no state change.
REQ-019 Each valid pixel (DATA_TAG0/1/END) shall increment pixel_count (saturating at 2^20-1) and fill the next byte lane of the pack register.
REQ-020 line_count shall start at 1 on the first valid pixel and increment when a valid pixel's tag differs from the previous valid pixel's DATA_TAG0/DATA_TAG1 tag.
REQ-021 On the edge sampling the 4th pixel of a word, the full word (out_bytes=4, out_last=0) shall be pushed into the FIFO; out_valid rises the following cycle if the FIFO was empty (latency 1 clk).
REQ-022 On the edge sampling DATA_END_TAG, the partial or full word shall be pushed with out_last=1, out_bytes=lanes filled, unused lanes zero.
REQ-023 FSM states: COLLECT (reset), DRAIN, DONE; COLLECT->DRAIN on END push; DRAIN->DONE when last word is popped; DONE->COLLECT only on rst/refresh.
REQ-024 In DRAIN and DONE all data_in shall be ignored; done=1 only in DONE.
REQ-025 FIFO is show-ahead; out_data/out_bytes/out_last shall be stable while out_valid=1 and out_ready=0.
REQ-026 Push while FIFO full and no pop in the same cycle: word dropped, overflow set sticky; push and pop in the same cycle when full shall succeed with no overflow.
REQ-027 A dropped END word shall still move the FSM to DONE directly (FIFO contents then drain normally).

Reset
REQ-028 rst or refresh shall, at the next edge, empty the FIFO, clear pack lanes, set state COLLECT, and drive out_valid=0, out_data=0, out_bytes=0, out_last=0, pixel_count=0, line_count=0, done=0, overflow=0, regardless of current state or in-flight handshake.

Structure
REQ-029 Tag constants and FSM state encodings shall live in a shared package/header used by the filter stages.
REQ-030 The FIFO shall be one sub-module, word_fifo (parameterised width/depth, show-ahead, full/empty).

Verification
REQ-031 Pixels 0x11,0x22,0x33,0x44 with TAG0, out_ready=1 -> out_data=0x44332211, out_bytes=4, one cycle after 4th pixel.
REQ-032 Pixels 0xA0,0xA1 (TAG0) then 0xA2 (END) -> out_data=0x00A2A1A0, out_bytes=3, out_last=1, then done=1, pixel_count=3.
REQ-033 Two lines of 4 px (TAG0 then TAG1) interleaved with INVALID slots -> line_count=2, pixel_count=8, two words, INVALID bytes absent.
REQ-034 out_ready=0 for 40 px (10 words, depth 8) -> overflow=1, exactly 8 words later delivered in order.
REQ-035 Assert refresh mid-word with out_valid=1 -> next cycle all outputs zero, state COLLECT, next frame packs from lane 0.
